// File: rtl/parking_pkg.sv
// Shared types and constants for the four-spot parking controller.
// Spot codes are {valid, idx[1:0]}; SPOT_NONE means no spot.
package parking_pkg;

  localparam int unsigned NUM_SPOTS      = 4;
  localparam logic [2:0]  SPOT_NONE      = 3'b000;
  localparam int unsigned SPOT_VALID_BIT = 2;
  localparam int unsigned SPOT_IDX_MSB   = 1;
  localparam int unsigned SPOT_IDX_LSB   = 0;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } state_t;

  function automatic logic [2:0] free_count_of(input logic [NUM_SPOTS-1:0] occ);
    logic [2:0] cnt;
    cnt = 3'(NUM_SPOTS);
    for (int i = 0; i < NUM_SPOTS; i++) begin
      if (occ[i]) cnt = cnt - 3'd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/parking_controller_if.sv
// Entry/exit handshake and status bundle between the lot logic and the controller.
// The master side drives the requests; the controller is the slave.
interface parking_if;
  import parking_pkg::*;

  logic                 entry_req;
  logic                 entry_ack;
  logic [2:0]           assigned_spot;
  logic                 exit_req;
  logic [1:0]           exit_spot;
  logic                 exit_ack;
  logic                 exit_err;
  logic [NUM_SPOTS-1:0] occupancy;
  logic [2:0]           free_count;
  logic                 full;
  logic                 gate_open;

  modport master (
    output entry_req, exit_req, exit_spot,
    input  entry_ack, assigned_spot, exit_ack, exit_err,
           occupancy, free_count, full, gate_open
  );

  modport slave (
    input  entry_req, exit_req, exit_spot,
    output entry_ack, assigned_spot, exit_ack, exit_err,
           occupancy, free_count, full, gate_open
  );
endinterface

// File: rtl/free_spot_finder.sv
// Lowest-zero priority encoder: occupancy map to spot code, spot 0 wins.
// Returns SPOT_NONE when every spot is taken.
module free_spot_finder
  import parking_pkg::*;
(
  input  logic [NUM_SPOTS-1:0] occupancy,
  output logic [2:0]           spot_code
);

  always_comb begin
    spot_code = SPOT_NONE;
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) spot_code = {1'b1, 2'(i)};
    end
  end

endmodule

// File: rtl/parking_controller.sv
// Gate and spot-allocation controller: grants the lowest free spot, times the
// entry gate, and releases spots on exit in any FSM state.
//
// state | meaning
// IDLE  | waiting for entry_req with a free spot
// OPEN  | car admitted, gate counter running
module parking_controller
  import parking_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 8
) (
  input logic     clk,
  input logic     rst_n,
  parking_if.slave bus
);

  state_t               state;
  logic [7:0]           gate_cnt;
  logic [NUM_SPOTS-1:0] occ;
  logic [2:0]           free_code;
  logic [2:0]           assigned_spot;
  logic                 entry_ack;
  logic                 exit_ack;
  logic                 exit_err;
  logic                 gate_open;
  logic                 grant;
  logic                 exit_hit;
  logic                 exit_miss;
  logic [NUM_SPOTS-1:0] set_mask;
  logic [NUM_SPOTS-1:0] clr_mask;

  free_spot_finder u_finder (
    .occupancy (occ),
    .spot_code (free_code)
  );

  // Grant index comes from the pre-release map, so a spot freed this cycle is never reused this cycle.
  assign grant     = (state == IDLE) && bus.entry_req && free_code[SPOT_VALID_BIT];
  assign exit_hit  = bus.exit_req && occ[bus.exit_spot];
  assign exit_miss = bus.exit_req && !occ[bus.exit_spot];

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (grant)    set_mask[free_code[SPOT_IDX_MSB:SPOT_IDX_LSB]] = 1'b1;
    if (exit_hit) clr_mask[bus.exit_spot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      gate_cnt      <= '0;
      occ           <= '0;
      assigned_spot <= SPOT_NONE;
      entry_ack     <= 1'b0;
      exit_ack      <= 1'b0;
      exit_err      <= 1'b0;
      gate_open     <= 1'b0;
    end else begin
      occ       <= (occ & ~clr_mask) | set_mask;
      entry_ack <= grant;
      exit_ack  <= exit_hit;
      exit_err  <= exit_miss;
      // Registered one cycle behind state, so the gate opens the cycle after entry_ack.
      gate_open <= (state == OPEN);
      case (state)
        IDLE: begin
          if (grant) begin
            assigned_spot <= free_code;
            gate_cnt      <= 8'(GATE_CYCLES);
            state         <= OPEN;
          end
        end
        OPEN: begin
          gate_cnt <= gate_cnt - 8'd1;
          if (gate_cnt == 8'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.entry_ack     = entry_ack;
  assign bus.assigned_spot = assigned_spot;
  assign bus.exit_ack      = exit_ack;
  assign bus.exit_err      = exit_err;
  assign bus.gate_open     = gate_open;
  assign bus.occupancy     = occ;
  assign bus.full          = &occ;
  assign bus.free_count    = free_count_of(occ);

endmodule

// File: tb/tb_parking_controller.sv
// Directed bench for parking_controller with GATE_CYCLES = 8.
module tb_parking_controller;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  parking_if bus ();

  parking_controller #(.GATE_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int bound, output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while (!bus.entry_ack && steps < bound);
  endtask

  task automatic do_exit(input logic [1:0] spot);
    bus.exit_req  = 1'b1;
    bus.exit_spot = spot;
    step();
    bus.exit_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    vectors++;
    if (bus.occupancy !== 4'b0000 || bus.free_count !== 3'd4 || bus.full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status occ=%b free=%0d full=%b expected occ=0000 free=4 full=0",
               bus.occupancy, bus.free_count, bus.full);
    end
    vectors++;
    if (bus.entry_ack !== 1'b0 || bus.exit_ack !== 1'b0 || bus.exit_err !== 1'b0 ||
        bus.assigned_spot !== 3'b000 || bus.gate_open !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs ack=%b xack=%b xerr=%b spot=%b gate=%b expected all zero",
               bus.entry_ack, bus.exit_ack, bus.exit_err, bus.assigned_spot, bus.gate_open);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_entry();
    int high_cnt;
    bus.entry_req = 1'b1;
    step();
    vectors++;
    if (bus.entry_ack !== 1'b1 || bus.assigned_spot !== 3'b100 ||
        bus.occupancy !== 4'b0001 || bus.free_count !== 3'd3) begin
      miscompares++;
      $display("FAIL first_grant ack=%b spot=%b occ=%b free=%0d expected ack=1 spot=100 occ=0001 free=3",
               bus.entry_ack, bus.assigned_spot, bus.occupancy, bus.free_count);
    end
    vectors++;
    if (bus.gate_open !== 1'b0) begin
      miscompares++;
      $display("FAIL gate_during_ack gate=%b expected 0", bus.gate_open);
    end
    bus.entry_req = 1'b0;
    high_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.gate_open === 1'b1) high_cnt++;
    end
    vectors++;
    if (high_cnt != 8) begin
      miscompares++;
      $display("FAIL gate_high_cycles got=%0d expected 8", high_cnt);
    end
    step();
    vectors++;
    if (bus.gate_open !== 1'b0 || bus.entry_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL gate_closed gate=%b ack=%b expected gate=0 ack=0", bus.gate_open, bus.entry_ack);
    end
  endtask

  task automatic test_fill();
    logic [2:0] exp_codes [4];
    int steps;
    int late;
    exp_codes[0] = 3'b100;
    exp_codes[1] = 3'b101;
    exp_codes[2] = 3'b110;
    exp_codes[3] = 3'b111;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.entry_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, steps);
      vectors++;
      if (bus.entry_ack !== 1'b1 || bus.assigned_spot !== exp_codes[k]) begin
        miscompares++;
        $display("FAIL fill_grant%0d ack=%b spot=%b expected ack=1 spot=%b",
                 k, bus.entry_ack, bus.assigned_spot, exp_codes[k]);
      end
      if (k > 0) begin
        vectors++;
        if (steps != 9) begin
          miscompares++;
          $display("FAIL grant_spacing%0d got=%0d expected 9", k, steps);
        end
      end
    end
    vectors++;
    if (bus.occupancy !== 4'b1111 || bus.full !== 1'b1 || bus.free_count !== 3'd0) begin
      miscompares++;
      $display("FAIL full_status occ=%b full=%b free=%0d expected occ=1111 full=1 free=0",
               bus.occupancy, bus.full, bus.free_count);
    end
    late = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.entry_ack === 1'b1) late++;
    end
    vectors++;
    if (late != 0) begin
      miscompares++;
      $display("FAIL ack_while_full got=%0d acks expected 0", late);
    end
  endtask

  task automatic test_exit_from_full();
    do_exit(2'd2);
    vectors++;
    if (bus.exit_ack !== 1'b1 || bus.occupancy !== 4'b1011 || bus.entry_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL exit_from_full xack=%b occ=%b ack=%b expected xack=1 occ=1011 ack=0",
               bus.exit_ack, bus.occupancy, bus.entry_ack);
    end
    step();
    vectors++;
    if (bus.entry_ack !== 1'b1 || bus.assigned_spot !== 3'b110 || bus.occupancy !== 4'b1111) begin
      miscompares++;
      $display("FAIL held_entry_grant ack=%b spot=%b occ=%b expected ack=1 spot=110 occ=1111",
               bus.entry_ack, bus.assigned_spot, bus.occupancy);
    end
    bus.entry_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_exit_err();
    do_exit(2'd3);
    do_exit(2'd1);
    vectors++;
    if (bus.occupancy !== 4'b0101) begin
      miscompares++;
      $display("FAIL setup_0101 occ=%b expected 0101", bus.occupancy);
    end
    do_exit(2'd1);
    vectors++;
    if (bus.exit_err !== 1'b1 || bus.exit_ack !== 1'b0 || bus.occupancy !== 4'b0101) begin
      miscompares++;
      $display("FAIL exit_free_spot xerr=%b xack=%b occ=%b expected xerr=1 xack=0 occ=0101",
               bus.exit_err, bus.exit_ack, bus.occupancy);
    end
    step();
    vectors++;
    if (bus.exit_err !== 1'b0) begin
      miscompares++;
      $display("FAIL exit_err_pulse xerr=%b expected 0", bus.exit_err);
    end
  endtask

  task automatic test_simultaneous();
    do_exit(2'd2);
    bus.entry_req = 1'b1;
    bus.exit_req  = 1'b1;
    bus.exit_spot = 2'd0;
    step();
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    vectors++;
    if (bus.entry_ack !== 1'b1 || bus.exit_ack !== 1'b1 ||
        bus.assigned_spot !== 3'b101 || bus.occupancy !== 4'b0010) begin
      miscompares++;
      $display("FAIL grant_and_exit ack=%b xack=%b spot=%b occ=%b expected ack=1 xack=1 spot=101 occ=0010",
               bus.entry_ack, bus.exit_ack, bus.assigned_spot, bus.occupancy);
    end
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_reset_mid_open();
    int steps;
    bus.entry_req = 1'b1;
    wait_ack(20, steps);
    bus.entry_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.entry_req = 1'b1;
    wait_ack(20, steps);
    bus.entry_req = 1'b0;
    step();
    step();
    vectors++;
    if (bus.occupancy !== 4'b0111 || bus.gate_open !== 1'b1) begin
      miscompares++;
      $display("FAIL setup_mid_open occ=%b gate=%b expected occ=0111 gate=1",
               bus.occupancy, bus.gate_open);
    end
    rst_n = 1'b0;
    step();
    vectors++;
    if (bus.gate_open !== 1'b0 || bus.occupancy !== 4'b0000 || bus.assigned_spot !== 3'b000 ||
        bus.free_count !== 3'd4) begin
      miscompares++;
      $display("FAIL reset_mid_open gate=%b occ=%b spot=%b free=%0d expected gate=0 occ=0000 spot=000 free=4",
               bus.gate_open, bus.occupancy, bus.assigned_spot, bus.free_count);
    end
    rst_n = 1'b1;
    bus.entry_req = 1'b1;
    step();
    bus.entry_req = 1'b0;
    vectors++;
    if (bus.entry_ack !== 1'b1 || bus.assigned_spot !== 3'b100) begin
      miscompares++;
      $display("FAIL idle_after_reset ack=%b spot=%b expected ack=1 spot=100",
               bus.entry_ack, bus.assigned_spot);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    bus.exit_spot = 2'd0;
    test_reset();
    test_first_entry();
    test_fill();
    test_exit_from_full();
    test_exit_err();
    test_simultaneous();
    test_reset_mid_open();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
